mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Multi-cycle integer multiply/divide unit owning the architectural HI and LO registers of the 32-bit MIPS core.
- Sits directly upstream of the 32-bit two-to-one writeback/result multiplexers: hi and lo feed the mux data inputs for MFHI/MFLO.
- Executes MULT, MULTU, DIV, DIVU iteratively (one bit per cycle) and supports MTHI/MTLO direct writes.

Parameters:
- WIDTH, 32, operand and HI/LO register width.
- COUNT_BITS, 5, iteration counter width; must satisfy 2**COUNT_BITS == WIDTH.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a new operation; sampled only in IDLE.
- operation  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- operand_a  input  WIDTH  multiplicand / dividend (rs).
- operand_b  input  WIDTH  multiplier / divisor (rt).
- write_hi  input  1  MTHI strobe.
- write_lo  input  1  MTLO strobe.
- write_data  input  WIDTH  data for MTHI/MTLO.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse: hi/lo hold the new result.
- hi  output  WIDTH  HI register (product upper half / remainder).
- lo  output  WIDTH  LO register (product lower half / quotient).

Behaviour:
- Reset (asynchronous): state IDLE, counter 0, hi = 0, lo = 0, busy = 0, done = 0, all internal datapath registers 0. Reset mid-operation aborts the operation; no partial result reaches hi/lo.
- States: IDLE, ITERATE, FIXUP, DONE.
- IDLE: start = 1 at edge E latches operation, operand magnitudes (signed ops: two's-complement absolute value; unsigned ops: raw), and result sign flags; goes to ITERATE with counter 0. busy rises after edge E.
- ITERATE: one iteration per edge, edges E+1 .. E+32; counter increments and wraps 31 -> 0, leaving ITERATE on the wrap.
  - Multiply: shift-add on 64-bit accumulator {upper, multiplier}; add multiplicand to upper when LSB = 1, then shift right one with carry-in.
  - Divide: restoring; shift {remainder, quotient} left one, trial-subtract divisor from remainder; if non-negative keep difference and set quotient LSB.
- FIXUP (edge E+33): sign correction, then hi/lo written.
  - MULT: 64-bit product negated when operand signs differ; hi = upper 32, lo = lower 32.
  - DIV: quotient negated when operand signs differ; remainder takes the dividend's sign.
  - Unsigned ops: no correction.
  - Goes to DONE.
- DONE: done = 1 and busy = 0 for exactly this one cycle; returns to IDLE on the next edge. start in DONE is ignored.
- Total latency: start sampled at edge E, result visible on hi/lo and done high after edge E+33.
- busy = 1 in ITERATE and FIXUP only.
- Divide by zero: no special case; the algorithm result stands. DIVU x/0 gives lo = 0xFFFFFFFF, hi = x.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0; no trap.
- start while busy or in DONE: ignored, no effect on the running operation.
- MTHI/MTLO: honoured only in IDLE; register updated at the edge, visible the next cycle. write_hi and write_lo together update both registers.
- Writes while busy or in DONE are dropped; the hazard unit must stall.
- start together with write_hi/write_lo in IDLE: start wins, the writes are dropped.
- hi/lo are stable at all times except the FIXUP edge and accepted MTHI/MTLO edges.

Test Plan:
1. Reset, MULTU 0xFFFFFFFF * 0xFFFFFFFF -> busy for 33 cycles; done pulses once, 34 cycles after start; hi = 0xFFFFFFFE, lo = 0x00000001.
2. MULT 0xFFFFFFFD (-3) * 0x00000007 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFEB. Then DIV 0xFFFFFFF9 (-7) / 0x00000002 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
3. DIVU 0x00000007 / 0 -> lo = 0xFFFFFFFF, hi = 0x00000007. Then DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
4. Start DIVU 100/7; at cycle 5 reassert start with MULTU 2*3 and pulse write_hi = 0x12345678 -> both ignored; final lo = 14, hi = 2.
5. Start MULTU; assert reset at cycle 10 -> busy, done, hi, lo go to 0 immediately (asynchronous), stay 0 after release; no done pulse.
6. In IDLE: write_lo = 0xCAFEF00D -> lo = 0xCAFEF00D next cycle, hi unchanged. Then start plus write_hi in the same cycle -> start accepted, hi not written by MTHI.

Source files
------------

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit owning HI/LO
//
// Purpose: executes signed/unsigned 32x32 multiply and divide one bit per
// cycle (shift-add / restoring division) on operand magnitudes, applies sign
// correction in a single FIXUP cycle, and owns the architectural HI/LO
// registers, which also accept MTHI/MTLO writes while idle.
//
// Ports:
//   clock       in   1      rising-edge clock
//   reset       in   1      asynchronous active-high reset
//   start       in   1      begin operation (sampled in IDLE only)
//   operation   in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   operand_a   in   WIDTH  multiplicand / dividend
//   operand_b   in   WIDTH  multiplier / divisor
//   write_hi    in   1      MTHI strobe (IDLE only)
//   write_lo    in   1      MTLO strobe (IDLE only)
//   write_data  in   WIDTH  MTHI/MTLO data
//   busy        out  1      ITERATE or FIXUP
//   done        out  1      one-cycle pulse, hi/lo hold the new result
//   hi          out  WIDTH  HI register (product upper / remainder)
//   lo          out  WIDTH  LO register (product lower / quotient)

module mult_div_unit #(
  parameter int WIDTH      = 32,
  parameter int COUNT_BITS = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         operation,
  input  logic [WIDTH-1:0]   operand_a,
  input  logic [WIDTH-1:0]   operand_b,
  input  logic               write_hi,
  input  logic               write_lo,
  input  logic [WIDTH-1:0]   write_data,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ITERATE = 2'd1;
  localparam logic [1:0] S_FIXUP   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]            r_state;
  logic [COUNT_BITS-1:0] r_count;
  logic                  r_is_div;
  logic                  r_neg_res;   // product / quotient must be negated
  logic                  r_neg_rem;   // remainder takes the dividend's sign
  logic [WIDTH-1:0]      r_upper;     // product upper half / partial remainder
  logic [WIDTH-1:0]      r_lower;     // multiplier being consumed / dividend becoming quotient
  logic [WIDTH-1:0]      r_mcand;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0]      r_hi;
  logic [WIDTH-1:0]      r_lo;

  logic                  w_signed_op;
  logic [WIDTH-1:0]      w_abs_a;
  logic [WIDTH-1:0]      w_abs_b;
  logic [WIDTH:0]        w_mul_sum;
  logic [WIDTH:0]        w_rem_shift;
  logic                  w_rem_ge;
  logic [WIDTH-1:0]      w_next_upper;
  logic [WIDTH-1:0]      w_next_lower;
  logic [2*WIDTH-1:0]    w_product;
  logic [WIDTH-1:0]      w_quot_fix;
  logic [WIDTH-1:0]      w_rem_fix;

  // operation[0] = 1 selects the unsigned variant
  assign w_signed_op = ~operation[0];
  assign w_abs_a     = (w_signed_op && operand_a[WIDTH-1]) ? (~operand_a + 1'b1) : operand_a;
  assign w_abs_b     = (w_signed_op && operand_b[WIDTH-1]) ? (~operand_b + 1'b1) : operand_b;

  always_comb begin
    w_mul_sum    = '0;
    w_rem_shift  = '0;
    w_rem_ge     = 1'b0;
    w_next_upper = r_upper;
    w_next_lower = r_lower;
    if (r_is_div) begin
      // Remainder can reach WIDTH+1 bits after the shift, so compare wide.
      w_rem_shift = {r_upper, r_lower[WIDTH-1]};
      w_rem_ge    = (w_rem_shift >= {1'b0, r_mcand});
      if (w_rem_ge) begin
        w_next_upper = WIDTH'(w_rem_shift - {1'b0, r_mcand});
      end else begin
        w_next_upper = w_rem_shift[WIDTH-1:0];
      end
      w_next_lower = {r_lower[WIDTH-2:0], w_rem_ge};
    end else begin
      // Add carry is shifted back into the accumulator's top bit.
      w_mul_sum    = {1'b0, r_upper} + (r_lower[0] ? {1'b0, r_mcand} : '0);
      w_next_upper = w_mul_sum[WIDTH:1];
      w_next_lower = {w_mul_sum[0], r_lower[WIDTH-1:1]};
    end
  end

  assign w_product  = r_neg_res ? (~{r_upper, r_lower} + 1'b1) : {r_upper, r_lower};
  assign w_quot_fix = r_neg_res ? (~r_lower + 1'b1) : r_lower;
  assign w_rem_fix  = r_neg_rem ? (~r_upper + 1'b1) : r_upper;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_upper   <= '0;
      r_lower   <= '0;
      r_mcand   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_ITERATE;
            r_count   <= '0;
            r_is_div  <= operation[1];
            r_neg_res <= w_signed_op && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
            r_neg_rem <= w_signed_op && operand_a[WIDTH-1];
            r_upper   <= '0;
            r_lower   <= operation[1] ? w_abs_a : w_abs_b;
            r_mcand   <= operation[1] ? w_abs_b : w_abs_a;
          end else begin
            // MTHI/MTLO only land here; start in the same cycle drops them.
            if (write_hi) r_hi <= write_data;
            if (write_lo) r_lo <= write_data;
          end
        end
        S_ITERATE: begin
          r_upper <= w_next_upper;
          r_lower <= w_next_lower;
          r_count <= r_count + 1'b1;
          if (r_count == {COUNT_BITS{1'b1}}) begin
            r_state <= S_FIXUP;
          end
        end
        S_FIXUP: begin
          if (r_is_div) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quot_fix;
          end else begin
            r_hi <= w_product[2*WIDTH-1:WIDTH];
            r_lo <= w_product[WIDTH-1:0];
          end
          r_state <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = (r_state == S_ITERATE) || (r_state == S_FIXUP);
  assign done = (r_state == S_DONE);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed self-checking bench for mult_div_unit

module tb_mult_div_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic [1:0]  operation;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        write_hi;
  logic        write_lo;
  logic [31:0] write_data;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_err = 0;
  int lat;
  int busy_cyc;
  int done_seen;

  mult_div_unit #(.WIDTH(32), .COUNT_BITS(5)) dut (
    .clock(clock), .reset(reset), .start(start), .operation(operation),
    .operand_a(operand_a), .operand_b(operand_b), .write_hi(write_hi),
    .write_lo(write_lo), .write_data(write_data), .busy(busy), .done(done),
    .hi(hi), .lo(lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a start for one edge (edge E); returns 1 ns after E.
  task automatic begin_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    operation = op; operand_a = a; operand_b = b; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  // Count negedges from the start edge until done; lat counts the done cycle.
  task automatic wait_done(input int already);
    lat = already;
    busy_cyc = 0;
    done_seen = 0;
    while (lat < 100 && done_seen == 0) begin
      @(negedge clock);
      lat++;
      if (busy) busy_cyc++;
      if (done) done_seen = 1;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    begin_op(op, a, b);
    wait_done(0);
    chk({tag, "_done"}, 32'(done_seen), 32'd1);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
    @(negedge clock);
    chk({tag, "_done_1cyc"}, {30'd0, done, busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; operation = 2'b00; operand_a = '0; operand_b = '0;
    write_hi = 1'b0; write_lo = 1'b0; write_data = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b0;

    // 1: MULTU max*max with latency and busy-length checks
    begin_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(0);
    chk("t1_latency", 32'(lat), 32'd34);
    chk("t1_busy_cycles", 32'(busy_cyc), 32'd33);
    chk("t1_hi", hi, 32'hFFFFFFFE);
    chk("t1_lo", lo, 32'h00000001);
    @(negedge clock);
    chk("t1_done_1cyc", {31'd0, done}, 32'd0);

    // 2: signed multiply and divide
    run_op("t2_mult", 2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("t2_div",  2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);

    // 3: divide by zero and signed overflow
    run_op("t3_divu0", 2'b11, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF);
    run_op("t3_ovf",   2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

    // 4: start and MTHI while busy are ignored
    begin_op(2'b11, 32'd100, 32'd7);
    repeat (4) @(negedge clock);
    start = 1'b1; operation = 2'b01; operand_a = 32'd2; operand_b = 32'd3;
    write_hi = 1'b1; write_data = 32'h12345678;
    @(posedge clock);
    #1 start = 1'b0; write_hi = 1'b0;
    chk("t4_hi_during", hi, 32'h00000000);
    wait_done(4);
    chk("t4_latency", 32'(lat), 32'd34);
    chk("t4_hi", hi, 32'd2);
    chk("t4_lo", lo, 32'd14);
    @(negedge clock);

    // 5: asynchronous reset mid-operation
    run_op("t5_pre", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42);
    begin_op(2'b01, 32'h00010000, 32'h00010000);
    repeat (9) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_done", {31'd0, done}, 32'd0);
    chk("t5_lo", lo, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done || busy || hi != 0 || lo != 0) done_seen = 1;
    end
    chk("t5_quiet_after", 32'(done_seen), 32'd0);

    // 6: MTLO in idle, then start beats a simultaneous MTHI
    @(negedge clock);
    write_lo = 1'b1; write_data = 32'hCAFEF00D;
    @(posedge clock);
    #1 write_lo = 1'b0;
    chk("t6_lo", lo, 32'hCAFEF00D);
    chk("t6_hi", hi, 32'h00000000);
    @(negedge clock);
    start = 1'b1; operation = 2'b01; operand_a = 32'd3; operand_b = 32'd5;
    write_hi = 1'b1; write_data = 32'h11111111;
    @(posedge clock);
    #1 start = 1'b0; write_hi = 1'b0;
    chk("t6_busy", {31'd0, busy}, 32'd1);
    chk("t6_hi_not_written", hi, 32'h00000000);
    wait_done(0);
    chk("t6_latency", 32'(lat), 32'd34);
    chk("t6_res_hi", hi, 32'd0);
    chk("t6_res_lo", lo, 32'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
